// File: rtl/aqed_pkg.sv
// Shared types and helpers for the A-QED FIFO functional-consistency monitor.
package aqed_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ORIG_WAIT = 2'd1,
    DUP_WAIT  = 2'd2,
    DONE      = 2'd3
  } aqed_state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_SEQ_W   = 8;
  localparam int DEF_MAX_LAT = 32;

  // Callers size-cast in and out, so one function serves every counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/aqed_capture_slot.sv
// One tagged output slot: remembers which output index to grab and latches that output once.
module aqed_capture_slot #(
  parameter int DATA_W = 16,
  parameter int SEQ_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tag_set,
  input  logic [SEQ_W-1:0]  tag_idx,
  input  logic              out_acc,
  input  logic [SEQ_W-1:0]  out_cnt,
  input  logic [DATA_W-1:0] out_data,
  output logic              seen,
  output logic [DATA_W-1:0] data
);

  logic              tagged_q;
  logic [SEQ_W-1:0]  idx_q;
  logic              eff_tagged;
  logic [SEQ_W-1:0]  eff_idx;
  logic              hit;

  // Bypass the index being tagged this cycle so a zero-latency read still matches.
  assign eff_tagged = tag_set | tagged_q;
  assign eff_idx    = tag_set ? tag_idx : idx_q;
  assign hit        = out_acc & eff_tagged & ~seen & (out_cnt == eff_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tagged_q <= 1'b0;
      idx_q    <= '0;
      seen     <= 1'b0;
      data     <= '0;
    end else begin
      if (tag_set) begin
        tagged_q <= 1'b1;
        idx_q    <= tag_idx;
      end
      if (hit) begin
        seen <= 1'b1;
        data <= out_data;
      end
    end
  end

endmodule

// File: rtl/aqed_fifo_monitor.sv
// A-QED monitor: forwards solver traffic to a FIFO-mode core, re-injects one tagged word, compares both outputs.
// Handshake: a write is accepted when bmc_v=1 and dut_full=0; a read is requested when acc_rdy=1 and dut_empty=0; an output is accepted whenever dut_valid_out=1.
module aqed_fifo_monitor
  import aqed_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEQ_W   = DEF_SEQ_W,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bmc_in,
  input  logic              bmc_v,
  input  logic              exec_dup,
  input  logic              acc_rdy,
  input  logic              dut_full,
  input  logic              dut_empty,
  input  logic [DATA_W-1:0] dut_data_out,
  input  logic              dut_valid_out,
  output logic [DATA_W-1:0] dut_data_in,
  output logic              dut_wen,
  output logic              dut_ren,
  output logic [SEQ_W-1:0]  seq_pointer,
  output logic              qed_done,
  output logic              qed_check,
  output logic              qed_timeout,
  output logic [1:0]        dbg_state
);

  localparam logic [SEQ_W-1:0] SEQ_MAX    = '1;
  localparam int               LAT_W      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_MAX    = '1;
  localparam logic [LAT_W-1:0] LAT_LIMIT  = LAT_W'(MAX_LAT);
  localparam logic             TIMEOUT_EN = (MAX_LAT != 0);

  aqed_state_e       state_q, state_d;
  logic [SEQ_W-1:0]  in_cnt, out_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] orig_data;
  logic              acc_w, in_sat, tag_orig, tag_dup, cap_en, timeout_hit;
  logic              orig_seen, dup_seen;
  logic [DATA_W-1:0] orig_out, dup_out;

  assign acc_w       = bmc_v & ~dut_full;
  assign in_sat      = (in_cnt == SEQ_MAX);
  assign tag_orig    = (state_q == IDLE) & acc_w & exec_dup & ~in_sat;
  assign tag_dup     = (state_q == ORIG_WAIT) & acc_w & exec_dup;
  assign cap_en      = dut_valid_out & (state_q != DONE);
  assign timeout_hit = TIMEOUT_EN & (state_q == DUP_WAIT) & ~dup_seen & (lat_cnt == LAT_LIMIT);

  assign dut_wen     = acc_w;
  assign dut_data_in = tag_dup ? orig_data : bmc_in;
  assign dut_ren     = acc_rdy & ~dut_empty;
  assign seq_pointer = in_cnt;
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tag_orig) state_d = ORIG_WAIT;
      ORIG_WAIT: if (tag_dup) state_d = DUP_WAIT;
      DUP_WAIT:  if (orig_seen & dup_seen) state_d = DONE;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      lat_cnt     <= '0;
      orig_data   <= '0;
      qed_done    <= 1'b0;
      qed_check   <= 1'b0;
      qed_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_w) in_cnt <= SEQ_W'(sat_inc(32'(in_cnt), 32'(SEQ_MAX)));
      if (dut_valid_out) out_cnt <= SEQ_W'(sat_inc(32'(out_cnt), 32'(SEQ_MAX)));
      if (tag_orig) orig_data <= bmc_in;
      if (tag_dup) lat_cnt <= '0;
      else if (state_q == DUP_WAIT) lat_cnt <= LAT_W'(sat_inc(32'(lat_cnt), 32'(LAT_MAX)));
      // Verdict is frozen at the first cycle both captures are present.
      if (orig_seen & dup_seen & ~qed_done) begin
        qed_done  <= 1'b1;
        qed_check <= (orig_out == dup_out);
      end
      if (timeout_hit) qed_timeout <= 1'b1;
    end
  end

  aqed_capture_slot #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_orig_slot (
    .clk      (clk),
    .reset    (reset),
    .tag_set  (tag_orig),
    .tag_idx  (in_cnt),
    .out_acc  (cap_en),
    .out_cnt  (out_cnt),
    .out_data (dut_data_out),
    .seen     (orig_seen),
    .data     (orig_out)
  );

  aqed_capture_slot #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_dup_slot (
    .clk      (clk),
    .reset    (reset),
    .tag_set  (tag_dup),
    .tag_idx  (in_cnt),
    .out_acc  (cap_en),
    .out_cnt  (out_cnt),
    .out_data (dut_data_out),
    .seen     (dup_seen),
    .data     (dup_out)
  );

endmodule

// File: tb/tb_aqed_fifo_monitor.sv
// Directed bench for aqed_fifo_monitor driving a small behavioural FIFO as the monitored core.
module tb_aqed_fifo_monitor;
  import aqed_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] bmc_in;
  logic        bmc_v, exec_dup, acc_rdy;
  logic        dut_full, dut_empty, dut_valid_out;
  logic [15:0] dut_data_out, dut_data_in;
  logic        dut_wen, dut_ren;
  logic [7:0]  seq_pointer;
  logic        qed_done, qed_check, qed_timeout;
  logic [1:0]  dbg_state;

  logic        force_full, corrupt;
  logic [15:0] fmem [16];
  logic [3:0]  wp, rp;
  logic [4:0]  fcnt;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  aqed_fifo_monitor #(.DATA_W(16), .SEQ_W(8), .MAX_LAT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bmc_in        (bmc_in),
    .bmc_v         (bmc_v),
    .exec_dup      (exec_dup),
    .acc_rdy       (acc_rdy),
    .dut_full      (dut_full),
    .dut_empty     (dut_empty),
    .dut_data_out  (dut_data_out),
    .dut_valid_out (dut_valid_out),
    .dut_data_in   (dut_data_in),
    .dut_wen       (dut_wen),
    .dut_ren       (dut_ren),
    .seq_pointer   (seq_pointer),
    .qed_done      (qed_done),
    .qed_check     (qed_check),
    .qed_timeout   (qed_timeout),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Zero-latency FIFO standing in for the memory core
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (dut_wen) begin
        fmem[wp] <= dut_data_in;
        wp       <= wp + 4'd1;
      end
      if (dut_ren) rp <= rp + 4'd1;
      fcnt <= fcnt + 5'(dut_wen) - 5'(dut_ren);
    end
  end

  assign dut_full      = force_full | (fcnt == 5'd16);
  assign dut_empty     = (fcnt == 5'd0);
  assign dut_valid_out = dut_ren;
  assign dut_data_out  = corrupt ? 16'hBEEE : fmem[rp];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks: all start and end 1ns after a rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; bmc_in = '0; bmc_v = 1'b0; exec_dup = 1'b0; acc_rdy = 1'b0;
    force_full = 1'b0; corrupt = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle();
  endtask

  task automatic wr(input logic [15:0] d, input logic dup, input logic [15:0] exp_in);
    bmc_in = d; bmc_v = 1'b1; exec_dup = dup;
    #1;
    check("wr_wen", 32'(dut_wen), 32'd1);
    check("wr_data_in", 32'(dut_data_in), 32'(exp_in));
    cycle();
    bmc_v = 1'b0; exec_dup = 1'b0;
  endtask

  task automatic rd();
    logic [15:0] exp;
    acc_rdy = 1'b1;
    #1;
    check("rd_ren", 32'(dut_ren), 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL rd_scoreboard: read with empty expected queue");
    end else begin
      exp = exp_q.pop_front();
      check("rd_data", 32'(dut_data_out), 32'(exp));
    end
    cycle();
    acc_rdy = 1'b0;
  endtask

  // Shared body of the correct / corrupted duplicate scenarios
  task automatic dup_scenario(input logic bad);
    wr(16'h1111, 1'b0, 16'h1111);
    wr(16'hBEEF, 1'b1, 16'hBEEF);
    check("dup_state_orig_wait", 32'(dbg_state), 32'(ORIG_WAIT));
    wr(16'h3333, 1'b0, 16'h3333);
    wr(16'h4444, 1'b0, 16'h4444);
    wr(16'h0000, 1'b1, 16'hBEEF);
    check("dup_state_dup_wait", 32'(dbg_state), 32'(DUP_WAIT));
    check("dup_seq_pointer", 32'(seq_pointer), 32'd5);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    exp_q.push_back(bad ? 16'hBEEE : 16'hBEEF);
    repeat (4) rd();
    corrupt = bad;
    rd();
    corrupt = 1'b0;
    check("dup_done_not_yet", 32'(qed_done), 32'd0);
    cycle();
    check("dup_done", 32'(qed_done), 32'd1);
    check("dup_check", 32'(qed_check), bad ? 32'd0 : 32'd1);
    check("dup_state_done", 32'(dbg_state), 32'(DONE));
    check("dup_no_timeout", 32'(qed_timeout), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    // Reset state
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_seq", 32'(seq_pointer), 32'd0);
    check("rst_done", 32'(qed_done), 32'd0);
    check("rst_check", 32'(qed_check), 32'd0);
    check("rst_timeout", 32'(qed_timeout), 32'd0);
    check("rst_wen", 32'(dut_wen), 32'd0);

    // Pass-through, no tagging
    wr(16'h0011, 1'b0, 16'h0011);
    wr(16'h0022, 1'b0, 16'h0022);
    wr(16'h0033, 1'b0, 16'h0033);
    wr(16'h0044, 1'b0, 16'h0044);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0033);
    exp_q.push_back(16'h0044);
    repeat (4) rd();
    check("pt_seq", 32'(seq_pointer), 32'd4);
    check("pt_done", 32'(qed_done), 32'd0);
    check("pt_state", 32'(dbg_state), 32'(IDLE));

    // Correct FIFO, then verdict holds while traffic continues
    do_reset();
    dup_scenario(1'b0);
    wr(16'h6666, 1'b0, 16'h6666);
    check("done_seq_runs", 32'(seq_pointer), 32'd6);
    check("done_hold", 32'(qed_done), 32'd1);
    check("check_hold", 32'(qed_check), 32'd1);

    // Corrupted duplicate output
    do_reset();
    dup_scenario(1'b1);

    // Full backpressure blocks the tag
    do_reset();
    force_full = 1'b1; bmc_in = 16'hAAAA; bmc_v = 1'b1; exec_dup = 1'b1;
    #1;
    check("full_wen", 32'(dut_wen), 32'd0);
    cycle();
    check("full_state", 32'(dbg_state), 32'(IDLE));
    check("full_seq", 32'(seq_pointer), 32'd0);
    force_full = 1'b0; bmc_v = 1'b0; exec_dup = 1'b0;
    wr(16'hAAAA, 1'b1, 16'hAAAA);
    check("full_release_state", 32'(dbg_state), 32'(ORIG_WAIT));
    check("full_release_seq", 32'(seq_pointer), 32'd1);

    // Timeout with reads held off: lat_cnt reaches 8 after 8 edges in DUP_WAIT, flag registers on the next
    wr(16'h5555, 1'b1, 16'hAAAA);
    check("to_state", 32'(dbg_state), 32'(DUP_WAIT));
    check("to_start", 32'(qed_timeout), 32'd0);
    repeat (8) cycle();
    check("to_before", 32'(qed_timeout), 32'd0);
    cycle();
    check("to_flag", 32'(qed_timeout), 32'd1);
    cycle();
    check("to_sticky", 32'(qed_timeout), 32'd1);
    check("to_no_done", 32'(qed_done), 32'd0);

    // Async reset mid-cycle while in DUP_WAIT
    #3;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    check("arst_timeout", 32'(qed_timeout), 32'd0);
    check("arst_seq", 32'(seq_pointer), 32'd0);
    check("arst_done", 32'(qed_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    wr(16'h7777, 1'b1, 16'h7777);
    check("arst_new_orig", 32'(dbg_state), 32'(ORIG_WAIT));
    wr(16'h0000, 1'b1, 16'h7777);
    exp_q.push_back(16'h7777);
    exp_q.push_back(16'h7777);
    rd();
    rd();
    cycle();
    check("arst_done_after", 32'(qed_done), 32'd1);
    check("arst_check_after", 32'(qed_check), 32'd1);

    // Input counter saturation: exec_dup ignored once in_cnt is full
    do_reset();
    bmc_v = 1'b1; acc_rdy = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bmc_in = 16'(i);
      cycle();
    end
    check("sat_seq", 32'(seq_pointer), 32'd255);
    exec_dup = 1'b1;
    #1;
    check("sat_wen", 32'(dut_wen), 32'd1);
    cycle();
    check("sat_state", 32'(dbg_state), 32'(IDLE));
    check("sat_done", 32'(qed_done), 32'd0);
    bmc_v = 1'b0; exec_dup = 1'b0; acc_rdy = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
